// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start bit, DBIT data bits LSB-first, optional parity, stop.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Stop phase may need up to 32 ticks, so the tick counter carries a fifth bit;
  // START/DATA/PARITY reset it before it ever passes 15.
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  function automatic logic parity_mismatch(input logic [DBIT-1:0] data,
                                           input logic            pbit,
                                           input logic            odd);
    parity_mismatch = ((^data) ^ pbit) != odd;
  endfunction

  state_t            state_r, state_n;
  logic              rx_meta_r, rx_sync_r;
  logic [4:0]        s_r, s_n;
  logic [2:0]        n_r, n_n;
  logic [DBIT-1:0]   shift_r, shift_n;
  logic [7:0]        dout_r, dout_n;
  logic              done_r, done_n;
  logic              frame_err_r, frame_err_n;
  logic              parity_err_r, parity_err_n;
`ifdef UART_RX_PARITY_EN
  logic              par_bit_r, par_bit_n;
`else
  logic              unused_par_odd_s;
  assign unused_par_odd_s = 1'(PAR_ODD);
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      s_r          <= 5'd0;
      n_r          <= 3'd0;
      shift_r      <= '0;
      dout_r       <= 8'd0;
      done_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_n;
      s_r          <= s_n;
      n_r          <= n_n;
      shift_r      <= shift_n;
      dout_r       <= dout_n;
      done_r       <= done_n;
      frame_err_r  <= frame_err_n;
      parity_err_r <= parity_err_n;
`ifdef UART_RX_PARITY_EN
      par_bit_r    <= par_bit_n;
`endif
    end
  end

  // Next-state and datapath updates; nothing moves outside IDLE without a tick.
  always_comb begin
    state_n      = state_r;
    s_n          = s_r;
    n_n          = n_r;
    shift_n      = shift_r;
    dout_n       = dout_r;
    done_n       = 1'b0;
    frame_err_n  = frame_err_r;
    parity_err_n = parity_err_r;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_n = ST_START;
          s_n     = 5'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_r == 5'd7) begin
            if (rx_sync_r) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DATA;
              s_n     = 5'd0;
              n_n     = 3'd0;
            end
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          s_n = s_r;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_r == 5'd15) begin
            s_n     = 5'd0;
            shift_n = {rx_sync_r, shift_r[DBIT-1:1]};
            if (n_r == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              n_n = n_r + 3'd1;
            end
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          s_n = s_r;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_r == 5'd15) begin
            par_bit_n = rx_sync_r;
            s_n       = 5'd0;
            state_n   = ST_STOP;
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          s_n = s_r;
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_r == STOP_LAST) begin
            state_n              = ST_IDLE;
            done_n               = 1'b1;
            dout_n               = 8'd0;
            dout_n[DBIT-1:0]     = shift_r;
            frame_err_n          = ~rx_sync_r;
`ifdef UART_RX_PARITY_EN
            parity_err_n = parity_mismatch(shift_r, par_bit_r, 1'(PAR_ODD));
`else
            parity_err_n = 1'b0;
`endif
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          s_n = s_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        s_n     = 5'd0;
        n_n     = 3'd0;
      end
    endcase
  end

  assign rx_done_tick = done_r;
  assign dout         = dout_r;
  assign frame_err    = frame_err_r;
  assign parity_err   = parity_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: s_tick every 4 clk, one bit = 64 clk.
module tb_uart_rx;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;

  int checks;
  int errors;
  int done_cnt;
  int base;
  int tcnt;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_ODD(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversampling strobe: 1-clk pulse every 4 clk.
  initial begin
    s_tick = 1'b0;
    tcnt   = 0;
    forever begin
      @(negedge clk);
      tcnt   = (tcnt == 3) ? 0 : tcnt + 1;
      s_tick = (tcnt == 3);
    end
  end

  // Count every clk on which the done pulse is high.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (rx_done_tick) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic par_on, input logic par_v);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (par_on) bit_time(par_v);
    bit_time(stop_v);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_done", 32'(rx_done_tick), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    reset_n = 1'b1;
    idle(100);

    // Clean 8N1 0xA5
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(64);
    check("a5_pulses", 32'(done_cnt - base), 32'd1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_ferr", 32'(frame_err), 32'd0);
    check("a5_perr", 32'(parity_err), 32'd0);

    // Glitch: low for 5 ticks only
    base = done_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(300);
    check("glitch_pulses", 32'(done_cnt - base), 32'd0);
    check("glitch_dout", 32'(dout), 32'hA5);

    // 0x3C with stop bit low
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(200);
    check("3c_pulses", 32'(done_cnt - base), 32'd1);
    check("3c_dout", 32'(dout), 32'h3C);
    check("3c_ferr", 32'(frame_err), 32'd1);

    // Clean 0x55 clears frame_err
    base = done_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(64);
    check("55_pulses", 32'(done_cnt - base), 32'd1);
    check("55_dout", 32'(dout), 32'h55);
    check("55_ferr", 32'(frame_err), 32'd0);

    // Back-to-back 0x00 then 0xFF
    base = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("b2b0_pulses", 32'(done_cnt - base), 32'd1);
    check("b2b0_dout", 32'(dout), 32'h00);
    check("b2b0_ferr", 32'(frame_err), 32'd0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(64);
    check("b2b1_pulses", 32'(done_cnt - base), 32'd2);
    check("b2b1_dout", 32'(dout), 32'hFF);
    check("b2b1_ferr", 32'(frame_err), 32'd0);

    // Reset in the middle of data bit 3 of 0x96
    base = done_cnt;
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_done", 32'(rx_done_tick), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_perr", 32'(parity_err), 32'd0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset_n = 1'b1;
    idle(200);
    check("mid_rst_pulses", 32'(done_cnt - base), 32'd0);
    base = done_cnt;
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    idle(64);
    check("0f_pulses", 32'(done_cnt - base), 32'd1);
    check("0f_dout", 32'(dout), 32'h0F);
    check("0f_ferr", 32'(frame_err), 32'd0);
    check("0f_perr", 32'(parity_err), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x81 has even ones: correct even parity bit is 0
    base = done_cnt;
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    idle(64);
    check("par1_pulses", 32'(done_cnt - base), 32'd1);
    check("par1_dout", 32'(dout), 32'h81);
    check("par1_perr", 32'(parity_err), 32'd1);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    idle(64);
    check("par0_pulses", 32'(done_cnt - base), 32'd2);
    check("par0_perr", 32'(parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
